seq_arith_8b_smul_accum: RTL



---
 rtl/seq_arith_8b_smul_accum.sv | 136 +++++++++++++
 1 files changed

// File: rtl/seq_arith_8b_smul_accum.sv
// rtl/seq_arith_8b_smul_accum.sv - signed 8x8 multiply-accumulate over a grouped operand stream
//
// Purpose:
//   Accepts signed 8-bit operand pairs, registers each exact 16-bit product
//   (stage P), then adds it into a signed ACC_NBITS-bit running sum (stage A).
//   When the pair flagged last has been accumulated, the sum, the pair count
//   (mod 256) and a sticky overflow flag are held on the output stream until
//   the downstream handshake, which clears the group state.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   istream_val/rdy             operand pair handshake
//   istream_in0/in1             signed 8-bit operands
//   istream_last                pair closes the current group
//   ostream_val/rdy             result handshake
//   ostream_sum                 signed group sum (ACC_NBITS bits)
//   ostream_count               pairs in the group, modulo 256
//   ostream_ovf                 signed accumulator overflow seen in the group
//
// Configuration:
//   SMUL_ACCUM_SAT_EN           defined: accumulator saturates on overflow;
//                               undefined: accumulator wraps. ovf set either way.

module seq_arith_8b_smul_accum #(
  parameter int ACC_NBITS = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 istream_val,
  output logic                 istream_rdy,
  input  logic [7:0]           istream_in0,
  input  logic [7:0]           istream_in1,
  input  logic                 istream_last,
  output logic                 ostream_val,
  input  logic                 ostream_rdy,
  output logic [ACC_NBITS-1:0] ostream_sum,
  output logic [7:0]           ostream_count,
  output logic                 ostream_ovf
);

  typedef enum logic {ACC, DONE} state_t;

  state_t                      state;
  logic signed [15:0]          p;
  logic                        p_val;
  logic                        p_last;
  logic signed [ACC_NBITS-1:0] acc;
  logic [7:0]                  count;
  logic                        ovf;

  logic                        accept;
  logic signed [15:0]          prod;
  logic signed [ACC_NBITS-1:0] p_ext;
  logic signed [ACC_NBITS-1:0] sum_wrap;
  logic signed [ACC_NBITS-1:0] acc_next;
  logic                        add_ovf;
  logic                        done;

`ifdef SMUL_ACCUM_SAT_EN
  localparam logic signed [ACC_NBITS-1:0] SAT_MAX = {1'b0, {(ACC_NBITS-1){1'b1}}};
  localparam logic signed [ACC_NBITS-1:0] SAT_MIN = {1'b1, {(ACC_NBITS-1){1'b0}}};
`endif

  // Input closes once a last pair sits in stage P so the next group cannot
  // start before this one has reached DONE.
  assign istream_rdy = (state == ACC) && !(p_val && p_last) && !reset;
  assign accept      = istream_val && istream_rdy;

  // 16x16 of sign-extended 8-bit operands; the full product range fits in 16 bits.
  assign prod     = 16'($signed(istream_in0)) * 16'($signed(istream_in1));
  assign p_ext    = ACC_NBITS'(p);
  assign sum_wrap = acc + p_ext;

  // Overflow: both addends share a sign and the result sign differs.
  assign add_ovf = (acc[ACC_NBITS-1] == p_ext[ACC_NBITS-1]) &&
                   (sum_wrap[ACC_NBITS-1] != acc[ACC_NBITS-1]);

  always_comb begin
    acc_next = sum_wrap;
`ifdef SMUL_ACCUM_SAT_EN
    // Direction follows the operands' common sign.
    if (add_ovf) begin
      acc_next = acc[ACC_NBITS-1] ? SAT_MIN : SAT_MAX;
    end
`endif
  end

  assign done          = (state == DONE) && !reset;
  assign ostream_val   = done;
  assign ostream_sum   = done ? acc   : '0;
  assign ostream_count = done ? count : 8'd0;
  assign ostream_ovf   = done && ovf;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ACC;
      acc    <= '0;
      count  <= 8'd0;
      ovf    <= 1'b0;
      p      <= '0;
      p_val  <= 1'b0;
      p_last <= 1'b0;
    end else begin
      p_val <= accept;
      if (accept) begin
        p      <= prod;
        p_last <= istream_last;
      end

      case (state)
        ACC: begin
          if (p_val) begin
            acc   <= acc_next;
            count <= count + 8'd1;
            if (add_ovf) begin
              ovf <= 1'b1;
            end
            if (p_last) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (ostream_rdy) begin
            acc   <= '0;
            count <= 8'd0;
            ovf   <= 1'b0;
            state <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule
